// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// with memory handshake, global stall, illegal-opcode trap and retirement counter.
module multicycle_control #(
    parameter bit SUPPORT_ORI = 1'b1,
    parameter bit TRAP_HALT   = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    input  logic             stall,
    output logic             pc_write,
    output logic             pc_write_cond_eq,
    output logic             pc_write_cond_ne,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic [1:0]       pc_source,
    output logic             illegal,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       pc_write;
        logic       cond_eq;
        logic       cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] aluop;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t           state, next_state;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    ctrl_t            c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else if (!stall) begin
            state <= next_state;
            if (state == S_DECODE) op_q <= opcode;
            if (next_state == S_TRAP) illegal_q <= 1'b1;
            if (retire) count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        c          = '0;
        case (state)
            S_FETCH: begin
                c.mem_read = 1'b1;
                c.src_b    = 2'b01;
                if (mem_ready) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                c.src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_RTYPE:       next_state = S_EXEC;
                    OP_ADDI:        next_state = S_IEXEC;
                    OP_ORI:         next_state = SUPPORT_ORI ? S_IEXEC : S_TRAP;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    default:        next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                c.src_a    = 1'b1;
                c.src_b    = 2'b10;
                next_state = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                next_state   = S_FETCH;
                retire       = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_EXEC: begin
                c.src_a    = 1'b1;
                c.aluop    = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                next_state  = S_FETCH;
                retire      = 1'b1;
            end
            S_IEXEC: begin
                c.src_a    = 1'b1;
                c.src_b    = 2'b10;
                c.aluop    = (SUPPORT_ORI && op_q == OP_ORI) ? 2'b11 : 2'b00;
                next_state = S_IWB;
            end
            S_IWB: begin
                c.reg_write = 1'b1;
                next_state  = S_FETCH;
                retire      = 1'b1;
            end
            S_BRANCH: begin
                c.src_a     = 1'b1;
                c.aluop     = 2'b01;
                c.pc_source = 2'b01;
                c.cond_eq   = (op_q == OP_BEQ);
                c.cond_ne   = (op_q == OP_BNE);
                next_state  = S_FETCH;
                retire      = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                next_state  = S_FETCH;
                retire      = 1'b1;
            end
            S_TRAP:  next_state = TRAP_HALT ? S_TRAP : S_FETCH;
            default: next_state = S_FETCH;
        endcase
    end

    // Strobes are killed by stall; selects and mem_read only by reset.
    logic live, strobe_ok;
    assign live      = !rst;
    assign strobe_ok = !rst && !stall;

    assign pc_write         = strobe_ok && c.pc_write;
    assign pc_write_cond_eq = strobe_ok && c.cond_eq;
    assign pc_write_cond_ne = strobe_ok && c.cond_ne;
    assign ir_write         = strobe_ok && c.ir_write;
    assign reg_write        = strobe_ok && c.reg_write;
    assign mem_write        = strobe_ok && c.mem_write;
    assign mem_read         = live && c.mem_read;
    assign iord             = live && c.iord;
    assign mem_to_reg       = live && c.mem_to_reg;
    assign reg_dst          = live && c.reg_dst;
    assign alu_src_a        = live && c.src_a;
    assign alu_src_b        = live ? c.src_b : 2'b00;
    assign aluop            = live ? c.aluop : 2'b00;
    assign pc_source        = live ? c.pc_source : 2'b00;
    assign illegal          = live && illegal_q;
    assign state_out        = live ? state : 4'd0;
    assign instr_count      = live ? count_q : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control: default build plus a
// SUPPORT_ORI=0 / TRAP_HALT=0 / CNT_W=2 build driven from the same inputs.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       stall = 1'b0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       eq;
        logic       ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] aluop;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    // default-parameter instance
    logic a_pcw, a_eq, a_ne, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw, a_sa, a_ill;
    logic [1:0] a_sb, a_op, a_ps;
    logic [3:0] a_state;
    logic [31:0] a_cnt;
    ctrl_t a_ctrl;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
        .pc_write(a_pcw), .pc_write_cond_eq(a_eq), .pc_write_cond_ne(a_ne),
        .iord(a_iord), .mem_read(a_mr), .mem_write(a_mw), .ir_write(a_irw),
        .mem_to_reg(a_m2r), .reg_dst(a_rd), .reg_write(a_rw), .alu_src_a(a_sa),
        .alu_src_b(a_sb), .aluop(a_op), .pc_source(a_ps), .illegal(a_ill),
        .state_out(a_state), .instr_count(a_cnt)
    );
    assign a_ctrl = {a_pcw, a_eq, a_ne, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rd, a_rw,
                     a_sa, a_sb, a_op, a_ps, a_ill};

    // no-ori, non-halting trap, 2-bit counter instance
    logic b_pcw, b_eq, b_ne, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rd, b_rw, b_sa, b_ill;
    logic [1:0] b_sb, b_op, b_ps;
    logic [3:0] b_state;
    logic [1:0] b_cnt;

    multicycle_control #(.SUPPORT_ORI(1'b0), .TRAP_HALT(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .stall(stall),
        .pc_write(b_pcw), .pc_write_cond_eq(b_eq), .pc_write_cond_ne(b_ne),
        .iord(b_iord), .mem_read(b_mr), .mem_write(b_mw), .ir_write(b_irw),
        .mem_to_reg(b_m2r), .reg_dst(b_rd), .reg_write(b_rw), .alu_src_a(b_sa),
        .alu_src_b(b_sb), .aluop(b_op), .pc_source(b_ps), .illegal(b_ill),
        .state_out(b_state), .instr_count(b_cnt)
    );

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ORI = 6'b001101, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_J = 6'b000010, OP_BAD = 6'b111111;

    localparam ctrl_t C_ZERO    = '0;
    localparam ctrl_t C_FETCH_H = '{mem_read:1'b1, src_b:2'b01, default:'0};
    localparam ctrl_t C_FETCH_W = '{pc_write:1'b1, ir_write:1'b1, mem_read:1'b1, src_b:2'b01, default:'0};
    localparam ctrl_t C_DEC     = '{src_b:2'b11, default:'0};
    localparam ctrl_t C_MEMADR  = '{src_a:1'b1, src_b:2'b10, default:'0};
    localparam ctrl_t C_MEMRD   = '{iord:1'b1, mem_read:1'b1, default:'0};
    localparam ctrl_t C_MEMWB   = '{mem_to_reg:1'b1, reg_write:1'b1, default:'0};
    localparam ctrl_t C_MEMWR   = '{iord:1'b1, mem_write:1'b1, default:'0};
    localparam ctrl_t C_EXEC    = '{src_a:1'b1, aluop:2'b10, default:'0};
    localparam ctrl_t C_ALUWB   = '{reg_dst:1'b1, reg_write:1'b1, default:'0};
    localparam ctrl_t C_ALUWB_S = '{reg_dst:1'b1, default:'0};
    localparam ctrl_t C_IEX_ADD = '{src_a:1'b1, src_b:2'b10, default:'0};
    localparam ctrl_t C_IEX_ORI = '{src_a:1'b1, src_b:2'b10, aluop:2'b11, default:'0};
    localparam ctrl_t C_IWB     = '{reg_write:1'b1, default:'0};
    localparam ctrl_t C_BEQ     = '{eq:1'b1, src_a:1'b1, aluop:2'b01, pc_source:2'b01, default:'0};
    localparam ctrl_t C_BNE     = '{ne:1'b1, src_a:1'b1, aluop:2'b01, pc_source:2'b01, default:'0};
    localparam ctrl_t C_JUMP    = '{pc_write:1'b1, pc_source:2'b10, default:'0};
    localparam ctrl_t C_TRAP    = '{illegal:1'b1, default:'0};

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        rdy;
        logic        stl;
        logic [3:0]  st;
        ctrl_t       c;
        int unsigned cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic stl,
                       input logic [3:0] st, input ctrl_t c, input int unsigned cnt);
        tbl.push_back('{r, op, rdy, stl, st, c, cnt});
    endtask

    // inputs change on the falling edge; outputs sampled 1 time unit later
    task automatic drive(input logic r, input logic [5:0] op, input logic rdy, input logic stl);
        @(negedge clk);
        rst = r; opcode = op; mem_ready = rdy; stall = stl;
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    initial begin
        //   rst op      rdy stl st  ctrl       cnt
        add(1, OP_R,    0, 0, 0,  C_ZERO,    0);   // reset, 2 cycles
        add(1, OP_R,    1, 0, 0,  C_ZERO,    0);
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 0);
        add(0, OP_LW,   1, 0, 1,  C_DEC,     0);   // lw with 3 wait cycles
        add(0, OP_LW,   0, 0, 2,  C_MEMADR,  0);
        add(0, OP_LW,   0, 0, 3,  C_MEMRD,   0);
        add(0, OP_LW,   0, 0, 3,  C_MEMRD,   0);
        add(0, OP_LW,   0, 0, 3,  C_MEMRD,   0);
        add(0, OP_LW,   1, 0, 3,  C_MEMRD,   0);
        add(0, OP_LW,   1, 0, 4,  C_MEMWB,   0);
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 1);
        add(0, OP_R,    1, 0, 1,  C_DEC,     1);   // add
        add(0, OP_R,    1, 0, 6,  C_EXEC,    1);
        add(0, OP_R,    1, 0, 7,  C_ALUWB,   1);
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 2);
        add(0, OP_BEQ,  1, 0, 1,  C_DEC,     2);   // beq
        add(0, OP_BEQ,  1, 0, 10, C_BEQ,     2);
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 3);
        add(0, OP_J,    1, 0, 1,  C_DEC,     3);   // j
        add(0, OP_J,    1, 0, 11, C_JUMP,    3);
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 4);
        add(0, OP_ORI,  1, 0, 1,  C_DEC,     4);   // ori; opcode changes after decode
        add(0, OP_R,    1, 0, 8,  C_IEX_ORI, 4);
        add(0, OP_R,    1, 0, 9,  C_IWB,     4);
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 5);
        add(0, OP_ADDI, 1, 0, 1,  C_DEC,     5);   // addi
        add(0, OP_ADDI, 1, 0, 8,  C_IEX_ADD, 5);
        add(0, OP_ADDI, 1, 0, 9,  C_IWB,     5);
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 6);
        add(0, OP_SW,   1, 0, 1,  C_DEC,     6);   // sw; opcode flips to lw later
        add(0, OP_LW,   1, 0, 2,  C_MEMADR,  6);
        add(0, OP_LW,   0, 0, 5,  C_MEMWR,   6);
        add(0, OP_LW,   1, 0, 5,  C_MEMWR,   6);
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 7);
        add(0, OP_BNE,  1, 0, 1,  C_DEC,     7);   // bne
        add(0, OP_BNE,  1, 0, 10, C_BNE,     7);
        add(0, OP_R,    0, 0, 0,  C_FETCH_H, 8);   // fetch waits on memory
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 8);
        add(0, OP_R,    1, 0, 1,  C_DEC,     8);   // add with stall in ALUWB
        add(0, OP_R,    1, 0, 6,  C_EXEC,    8);
        add(0, OP_R,    1, 1, 7,  C_ALUWB_S, 8);
        add(0, OP_R,    1, 1, 7,  C_ALUWB_S, 8);
        add(0, OP_R,    1, 0, 7,  C_ALUWB,   8);
        add(0, OP_R,    1, 1, 0,  C_FETCH_H, 9);   // stall beats mem_ready
        add(0, OP_R,    1, 0, 0,  C_FETCH_W, 9);
        add(0, OP_R,    1, 0, 1,  C_DEC,     9);   // reset aborts in ALUWB
        add(0, OP_R,    1, 0, 6,  C_EXEC,    9);
        add(1, OP_R,    1, 0, 0,  C_ZERO,    0);
        add(0, OP_R,    0, 0, 0,  C_FETCH_H, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].op, tbl[i].rdy, tbl[i].stl);
            chk($sformatf("v%0d state", i), a_state, tbl[i].st);
            chk($sformatf("v%0d ctrl", i), a_ctrl, tbl[i].c);
            chk($sformatf("v%0d count", i), a_cnt, tbl[i].cnt);
        end

        // illegal opcode parks in TRAP with no strobes until reset
        drive(0, OP_R, 1, 0);
        chk("trap fetch", a_ctrl, C_FETCH_W);
        drive(0, OP_BAD, 1, 0);
        chk("trap decode", a_state, 1);
        for (int k = 0; k < 10; k++) begin
            drive(0, OP_BAD, 1, 0);
            chk($sformatf("trap park%0d state", k), a_state, 12);
            chk($sformatf("trap park%0d ctrl", k), a_ctrl, C_TRAP);
        end
        drive(1, OP_R, 0, 0);
        chk("trap rst state", a_state, 0);
        drive(0, OP_R, 0, 0);
        chk("trap cleared", a_ctrl, C_FETCH_H);
        chk("trap count", a_cnt, 0);

        // ori without support traps once, then refetches with illegal sticky
        drive(0, OP_R, 1, 0);
        chk("noori fetch", b_state, 0);
        drive(0, OP_ORI, 1, 0);
        chk("noori decode", b_state, 1);
        drive(0, OP_R, 1, 0);
        chk("noori trap", b_state, 12);
        chk("noori illegal", b_ill, 1);
        chk("noori trap no strobe", {b_pcw, b_irw, b_rw, b_mw}, 0);
        chk("ori iexec main", a_ctrl, C_IEX_ORI);
        drive(0, OP_R, 0, 0);
        chk("noori refetch", b_state, 0);
        chk("noori sticky", b_ill, 1);
        chk("ori iwb main", a_ctrl, C_IWB);
        drive(1, OP_R, 0, 0);
        drive(0, OP_R, 0, 0);
        chk("noori illegal clr", b_ill, 0);

        // five jumps: 32-bit count 5, 2-bit count wraps to 1
        for (int k = 0; k < 5; k++) begin
            drive(0, OP_R, 1, 0);
            drive(0, OP_J, 1, 0);
            drive(0, OP_J, 1, 0);
            chk($sformatf("jump%0d ctrl", k), a_ctrl, C_JUMP);
        end
        drive(0, OP_R, 0, 0);
        chk("wrap count main", a_cnt, 5);
        chk("wrap count cnt2", b_cnt, 1);
        chk("wrap state cnt2", b_state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
